// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage PC generator and its branch target buffer.
package pc_gen_pkg;

  localparam int unsigned DataWidth      = 32;
  typedef logic [DataWidth-1:0] data_t;

  localparam int unsigned DefInstBytes   = 4;
  localparam data_t       DefResetVector = 32'h0000_0000;

  typedef enum logic [1:0] {
    Snt = 2'b00,
    Wnt = 2'b01,
    Wt  = 2'b10,
    St  = 2'b11
  } cnt_e;

  // Tag is kept zero-extended to full width so any BTB depth fits the same struct.
  typedef struct packed {
    logic  valid;
    data_t tag;
    data_t target;
    cnt_e  cnt;
  } btb_entry_t;

  function automatic cnt_e sat_update(cnt_e cnt, logic taken);
    cnt_e res;
    res = cnt;
    unique case (cnt)
      Snt: res = taken ? Wnt : Snt;
      Wnt: res = taken ? Wt  : Snt;
      Wt:  res = taken ? St  : Wnt;
      St:  res = taken ? St  : Wt;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-control bundle between the PC generator (slave) and the pipeline that steers it (master).
interface pc_gen_if
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN = DataWidth
);
  logic            stall;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            bu_valid;
  logic [XLEN-1:0] bu_pc;
  logic [XLEN-1:0] bu_target;
  logic            bu_taken;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_p4;
  logic            pc_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  modport master (
    output stall, trap_valid, trap_pc, redirect_valid, redirect_pc,
    output bu_valid, bu_pc, bu_target, bu_taken,
    input  pc, pc_p4, pc_valid, pred_taken, pred_target
  );

  modport slave (
    input  stall, trap_valid, trap_pc, redirect_valid, redirect_pc,
    input  bu_valid, bu_pc, bu_target, bu_taken,
    output pc, pc_p4, pc_valid, pred_taken, pred_target
  );
endinterface

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational and sees pre-update contents when an update hits the same entry.
module pc_gen_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned Entries = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  data_t lookup_pc_i,
  input  logic  bu_valid_i,
  input  data_t bu_pc_i,
  input  data_t bu_target_i,
  input  logic  bu_taken_i,
  output logic  pred_taken_o,
  output data_t pred_target_o
);

  localparam int unsigned IdxW = $clog2(Entries);

  btb_entry_t btb_q [Entries];
  btb_entry_t btb_d [Entries];

  logic [IdxW-1:0] rd_idx, wr_idx;
  data_t           rd_tag, wr_tag, wr_tgt;
  btb_entry_t      rd_e, wr_e;
  logic            rd_hit, wr_hit;

  assign rd_idx = lookup_pc_i[IdxW+1:2];
  assign rd_tag = lookup_pc_i >> (IdxW + 2);
  assign rd_e   = btb_q[rd_idx];
  assign rd_hit = rd_e.valid && (rd_e.tag == rd_tag);

  assign pred_taken_o  = rd_hit && rd_e.cnt[1];
  assign pred_target_o = rd_e.target;

  assign wr_idx = bu_pc_i[IdxW+1:2];
  assign wr_tag = bu_pc_i >> (IdxW + 2);
  assign wr_tgt = {bu_target_i[DataWidth-1:2], 2'b00};
  assign wr_e   = btb_q[wr_idx];
  assign wr_hit = wr_e.valid && (wr_e.tag == wr_tag);

  logic unused_lo;
  assign unused_lo = ^{lookup_pc_i[1:0], bu_pc_i[1:0], bu_target_i[1:0]};

  always_comb begin
    btb_d = btb_q;
    if (bu_valid_i) begin
      if (wr_hit) begin
        btb_d[wr_idx].cnt = sat_update(wr_e.cnt, bu_taken_i);
        if (bu_taken_i) begin
          btb_d[wr_idx].target = wr_tgt;
        end
      end else if (bu_taken_i) begin
        btb_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_tgt, cnt: Wt};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Entries); i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: Wnt};
      end
    end else begin
      btb_q <= btb_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC register with trap/redirect/stall priority and optional BTB prediction.
// Define PC_GEN_BTB_EN to build the branch target buffer; otherwise fetch is purely sequential.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = DataWidth,
  parameter logic [XLEN-1:0] RESET_VECTOR = DefResetVector,
  parameter int unsigned     BTB_ENTRIES  = 16,
  parameter int unsigned     INST_BYTES   = DefInstBytes
) (
  input logic        clk,
  input logic        rst_n,
  pc_gen_if.slave    bus
);

  logic [XLEN-1:0] pc_q, pc_d, pc_p4, next_pc, btb_target;
  logic            pc_valid_q, pc_valid_d, btb_taken;

  assign pc_p4 = pc_q + XLEN'(INST_BYTES);

`ifdef PC_GEN_BTB_EN
  pc_gen_btb #(
    .Entries (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc_i   (pc_q),
    .bu_valid_i    (bus.bu_valid),
    .bu_pc_i       (bus.bu_pc),
    .bu_target_i   (bus.bu_target),
    .bu_taken_i    (bus.bu_taken),
    .pred_taken_o  (btb_taken),
    .pred_target_o (btb_target)
  );
`else
  assign btb_taken  = 1'b0;
  assign btb_target = pc_p4;

  logic unused_bu;
  assign unused_bu = ^{bus.bu_valid, bus.bu_pc, bus.bu_target, bus.bu_taken};
`endif

  // Trap and redirect flush past a stall; the first edge after reset only marks the PC valid.
  always_comb begin
    next_pc = pc_p4;
    if (bus.trap_valid) begin
      next_pc = bus.trap_pc;
    end else if (bus.redirect_valid) begin
      next_pc = bus.redirect_pc;
    end else if (bus.stall) begin
      next_pc = pc_q;
    end else if (btb_taken) begin
      next_pc = btb_target;
    end

    pc_valid_d = 1'b1;
    pc_d       = pc_q;
    if (pc_valid_q) begin
      pc_d = {next_pc[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      pc_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_p4       = pc_p4;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.pred_taken  = btb_taken;
  assign bus.pred_target = btb_taken ? btb_target : pc_p4;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, BTB corner sequences and a random
// run scored against a behavioural model of the next-PC rules.
module tb_pc_gen;

  localparam int unsigned Xlen     = 32;
  localparam logic [31:0] ResetVec = 32'h0000_0100;
  localparam int unsigned Entries  = 16;
`ifdef PC_GEN_BTB_EN
  localparam bit BtbEn = 1'b1;
`else
  localparam bit BtbEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pc_gen_if #(.XLEN(Xlen)) bus ();

  pc_gen #(
    .XLEN         (Xlen),
    .RESET_VECTOR (ResetVec),
    .BTB_ENTRIES  (Entries),
    .INST_BYTES   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural PC plus a BTB held as plain arrays.
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_v   [Entries];
  logic [31:0] m_tag [Entries];
  logic [31:0] m_tgt [Entries];
  int          m_cnt [Entries];

  function automatic int unsigned m_idx(input logic [31:0] a);
    return (a / 4) % Entries;
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a / (4 * Entries);
  endfunction

  function automatic bit m_pred();
    int unsigned i;
    i = m_idx(m_pc);
    return BtbEn && m_v[i] && (m_tag[i] == m_tagof(m_pc)) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt();
    return m_pred() ? m_tgt[m_idx(m_pc)] : m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc    = ResetVec;
    m_valid = 1'b0;
    for (int i = 0; i < int'(Entries); i++) begin
      m_v[i]   = 1'b0;
      m_cnt[i] = 1;
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    int unsigned i;
    bit          hit;
    if (m_valid) begin
      if (bus.trap_valid)          nxt = bus.trap_pc;
      else if (bus.redirect_valid) nxt = bus.redirect_pc;
      else if (bus.stall)          nxt = m_pc;
      else if (m_pred())           nxt = m_tgt[m_idx(m_pc)];
      else                         nxt = m_pc + 32'd4;
      m_pc = nxt & ~32'd3;
    end
    m_valid = 1'b1;
    if (BtbEn && bus.bu_valid) begin
      i   = m_idx(bus.bu_pc);
      hit = m_v[i] && (m_tag[i] == m_tagof(bus.bu_pc));
      if (hit) begin
        if (bus.bu_taken) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = bus.bu_target & ~32'd3;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (bus.bu_taken) begin
        m_v[i]   = 1'b1;
        m_tag[i] = m_tagof(bus.bu_pc);
        m_tgt[i] = bus.bu_target & ~32'd3;
        m_cnt[i] = 2;
      end
    end
  endtask

  task automatic set_in(input bit st, input bit tv, input logic [31:0] tp,
                        input bit rv, input logic [31:0] rp);
    bus.stall          = st;
    bus.trap_valid     = tv;
    bus.trap_pc        = tp;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
  endtask

  task automatic set_bu(input bit v, input logic [31:0] bpc, input logic [31:0] tgt,
                        input bit tk);
    bus.bu_valid  = v;
    bus.bu_pc     = bpc;
    bus.bu_target = tgt;
    bus.bu_taken  = tk;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"},          bus.pc,                m_pc);
    check({tag, "_pc_valid"},    32'(bus.pc_valid),     32'(m_valid));
    check({tag, "_pc_p4"},       bus.pc_p4,             m_pc + 32'd4);
    check({tag, "_pred_taken"},  32'(bus.pred_taken),   32'(m_pred()));
    check({tag, "_pred_target"}, bus.pred_target,       m_pred_tgt());
  endtask

  typedef struct {
    bit          stall;
    bit          trap_v;
    logic [31:0] trap_pc;
    bit          redir_v;
    logic [31:0] redir_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         32'h104,       32'h108};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         32'h108,       32'h10C};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,         32'h108,       32'h10C};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,         32'h108,       32'h10C};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,         32'h108,       32'h10C};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         32'h10C,       32'h110};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h200,       32'h200,       32'h204};
    vecs[7]  = '{1'b1, 1'b1, 32'h80, 1'b1, 32'h200,       32'h80,        32'h84};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h203,       32'h200,       32'h204};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,         32'h0,         32'h4};
    vecs[11] = '{1'b0, 1'b1, 32'h37, 1'b0, 32'h0,         32'h34,        32'h38};

    set_in(1'b0, 1'b0, '0, 1'b0, '0);
    set_bu(1'b0, '0, '0, 1'b0);
    model_reset();

    // Reset and first edge after release.
    #12;
    check("rst_pc", bus.pc, ResetVec);
    check("rst_pc_valid", 32'(bus.pc_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_pc", bus.pc, ResetVec);
    check("rel_pc_valid", 32'(bus.pc_valid), 32'd1);

    foreach (vecs[k]) begin
      set_in(vecs[k].stall, vecs[k].trap_v, vecs[k].trap_pc, vecs[k].redir_v, vecs[k].redir_pc);
      tick();
      check($sformatf("vec%0d_pc", k), bus.pc, vecs[k].exp_pc);
      check($sformatf("vec%0d_p4", k), bus.pc_p4, vecs[k].exp_p4);
    end

    // BTB training: allocate 0x40 -> 0x80, then weaken with two not-taken updates.
    set_in(1'b0, 1'b0, '0, 1'b1, 32'h40);
    set_bu(1'b1, 32'h40, 32'h80, 1'b1);
    tick();
    set_in(1'b0, 1'b0, '0, 1'b0, '0);
    set_bu(1'b0, '0, '0, 1'b0);
    check("train_pc", bus.pc, 32'h40);
    check("train_pred_taken", 32'(bus.pred_taken), 32'(BtbEn));
    check("train_pred_target", bus.pred_target, BtbEn ? 32'h80 : 32'h44);
    tick();
    check("train_next_pc", bus.pc, BtbEn ? 32'h80 : 32'h44);
    set_in(1'b0, 1'b0, '0, 1'b1, 32'h40);
    set_bu(1'b1, 32'h40, 32'h80, 1'b0);
    tick();
    set_in(1'b1, 1'b0, '0, 1'b0, '0);
    tick();
    set_in(1'b0, 1'b0, '0, 1'b0, '0);
    set_bu(1'b0, '0, '0, 1'b0);
    check("untrain_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("untrain_pred_target", bus.pred_target, 32'h44);
    tick();
    check("untrain_next_pc", bus.pc, 32'h44);

    // Asynchronous reset mid-operation takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", bus.pc, ResetVec);
    check("midrst_pc_valid", 32'(bus.pc_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_rel_pc_valid", 32'(bus.pc_valid), 32'd1);

    // Aliasing at index 0; the update in the same cycle as a lookup of 0x40 must not affect it.
    set_in(1'b0, 1'b0, '0, 1'b1, 32'h40);
    set_bu(1'b1, 32'h40, 32'h80, 1'b1);
    tick();
    check("alias_first_pred", 32'(bus.pred_taken), 32'(BtbEn));
    set_in(1'b0, 1'b0, '0, 1'b0, '0);
    set_bu(1'b1, 32'h80, 32'h200, 1'b1);
    tick();
    set_bu(1'b0, '0, '0, 1'b0);
    check("alias_same_cycle_pc", bus.pc, BtbEn ? 32'h80 : 32'h44);
    check("alias_new_pred", 32'(bus.pred_taken), 32'(BtbEn));
    check("alias_new_target", bus.pred_target, BtbEn ? 32'h200 : 32'h48);
    set_in(1'b0, 1'b0, '0, 1'b1, 32'h40);
    tick();
    set_in(1'b0, 1'b0, '0, 1'b0, '0);
    check("alias_old_pred", 32'(bus.pred_taken), 32'd0);
    check("alias_old_target", bus.pred_target, 32'h44);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 1023));
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
             $urandom_range(0, 9) == 0, rp);
      set_bu($urandom_range(0, 1) == 1,
             ($urandom_range(0, 1) == 1) ? m_pc : 32'($urandom_range(0, 255)) << 2,
             32'($urandom_range(0, 255)) << 2,
             $urandom_range(0, 2) != 0);
      @(negedge clk);
      check_model("rand");
      tick();
    end
    @(negedge clk);
    check_model("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation fetch-stage program-counter generator.
- Adds a fixed reset vector, prioritised redirect sources (trap, execute-stage redirect) and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters for next-PC prediction.
- Sits at the head of the fetch stage and drives the instruction-memory address and the fetch/decode pipeline register.
- Replaces the earlier single-source PC register and its pre-decrement reset workaround.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset release.
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256.
- INST_BYTES, 4, sequential increment in bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- stall  in  1  hold the current PC (hazard or memory wait).
- trap_valid  in  1  exception/interrupt redirect request.
- trap_pc  in  XLEN  trap handler address.
- redirect_valid  in  1  execute-stage redirect (mispredict or jump resolve).
- redirect_pc  in  XLEN  corrected target.
- bu_valid  in  1  resolved branch/jump update to the BTB.
- bu_pc  in  XLEN  PC of the resolved branch.
- bu_target  in  XLEN  resolved target.
- bu_taken  in  1  resolved direction.
- pc  out  XLEN  current fetch PC.
- pc_p4  out  XLEN  pc + INST_BYTES, wraps modulo 2^XLEN.
- pc_valid  out  1  pc is a real fetch address.
- pred_taken  out  1  BTB predicts taken for pc (combinational).
- pred_target  out  XLEN  predicted next PC: BTB target if pred_taken, else pc_p4.

Behaviour:
- Reset (asynchronous): pc=RESET_VECTOR, pc_valid=0, all BTB valid bits=0, counters=2'b01. First rising edge after release sets pc_valid=1; pc holds RESET_VECTOR for that edge.
- pc_valid stays 1 until the next reset; reset asserted mid-operation returns to the reset state immediately.
- Next-PC priority, evaluated each rising edge while pc_valid=1, highest first:
  1. trap_valid -> trap_pc.
  2. redirect_valid -> redirect_pc.
  3. stall -> pc (hold).
  4. pred_taken -> BTB target.
  5. otherwise pc_p4.
- trap and redirect override stall (flush semantics).
- The loaded value always has bits [1:0] forced to 0.
- BTB lookup:
  - index = pc[IDX+1:2], IDX = log2(BTB_ENTRIES); tag = pc[XLEN-1:IDX+2].
  - hit = valid & tag match; pred_taken = hit & counter[1].
  - Zero-cycle latency (combinational read).
- BTB update, on a rising edge with bu_valid:
  - Miss and bu_taken: allocate (overwrite) the entry with valid=1, tag, target=bu_target, counter=2'b10.
  - Miss and not taken: no change.
  - Hit: counter increments if taken (saturate at 2'b11), decrements if not taken (saturate at 2'b00); target rewritten when taken.
- bu_valid is independent of stall, trap and redirect.
- Same-cycle update and lookup at the same index: lookup returns the pre-update contents; the new contents are visible the next cycle.
- pc_p4 at 32'hFFFF_FFFC equals 32'h0000_0000.

Optional Feature:
- Macro PC_GEN_BTB_EN.
- Defined: BTB present as described.
- Undefined: no BTB storage; pred_taken tied 0; pred_target = pc_p4; bu_* ports present but ignored; next-PC priority skips step 4.

Decomposition:
- Package defines holds:
  - data_t (XLEN-wide).
  - INST_BYTES default.
  - RESET_VECTOR default.
  - btb_entry_t struct {valid, tag, target, cnt[1:0]}.
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- One sub-module, btb: lookup/update storage and counter logic, instantiated only under PC_GEN_BTB_EN.
- pc_gen keeps the PC register and the priority mux.

Test Plan:
- Reset release with RESET_VECTOR=32'h100 -> pc_valid 0 during reset; after release pc=0x100, pc_valid=1, then 0x104, 0x108 on successive edges.
- stall high 3 cycles at pc=0x108 -> pc holds 0x108; on release advances to 0x10C.
- stall=1 with redirect_valid=1, redirect_pc=0x200 -> pc=0x200 next edge. Same cycle with trap_valid=1, trap_pc=0x80 -> pc=0x80.
- redirect_pc=0x203 -> pc=0x200 (low bits cleared).
- BTB training:
  - bu_valid, bu_pc=0x40, bu_target=0x80, taken -> next fetch of 0x40 gives pred_taken=1, next pc=0x80.
  - Two not-taken updates -> pred_taken=0, next pc=0x44.
- Aliasing with 16 entries: taken update for 0x40 then for 0x80 (same index, different tag) -> 0x40 now misses, pred_target=0x44.
- Wrap: redirect to 0xFFFF_FFFC, no BTB hit -> next pc=0x0. With PC_GEN_BTB_EN undefined, the BTB training scenario gives pred_taken=0 throughout.
